// File: rtl/layer_serializer.sv
// layer_serializer: gathers one value per upstream neuron into a holding bank,
// then replays the whole set as a gapless serial stream (neuron 0 first) that
// feeds the neuron_in/neuron_in_valid inputs of the next layer. The holding
// bank and the shift buffer form a double buffer, so collection of set N+1
// overlaps streaming of set N.
module layer_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16,
    parameter int cntWidth   = $clog2(numNeurons + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons-1:0]           layer_in_valid,
    input  logic [numNeurons*dataWidth-1:0] layer_in,
    output logic                            data_out_valid,
    output logic [dataWidth-1:0]            data_out,
    output logic                            busy,
    output logic                            overrun
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Control state
    state_t                state_r;
    state_t                state_s;
    logic [cntWidth-1:0]   cnt_r;
    logic [cntWidth-1:0]   cnt_s;
    logic [numNeurons-1:0] flag_r;
    logic [numNeurons-1:0] flag_s;

    // Holding bank (collect side) and shift buffer (stream side)
    logic [dataWidth-1:0]  hold_r [numNeurons];
    logic [dataWidth-1:0]  sbuf_r [numNeurons];

    // Output registers and their next values
    logic [dataWidth-1:0]  data_out_r;
    logic [dataWidth-1:0]  data_out_s;
    logic                  data_out_valid_r;
    logic                  data_out_valid_s;
    logic                  overrun_r;
    logic                  overrun_s;
    logic                  busy_r;
    logic                  busy_s;

    // Decode helpers
    logic                  complete_s;
    logic                  last_s;
    logic                  transfer_s;
    logic [dataWidth-1:0]  sel_s;

    // Transfer decision: the registered flags form a complete set and the
    // stream side is either idle or presenting its final element.
    always_comb begin
        complete_s = &flag_r;
        last_s     = (cnt_r == cntWidth'(numNeurons));
        if (complete_s && ((state_r == IDLE) || ((state_r == STREAM) && last_s))) begin
            transfer_s = 1'b1;
        end else begin
            transfer_s = 1'b0;
        end
    end

    // Shift-buffer read mux; written as a compare chain so the counter width
    // never has to match the array index width.
    always_comb begin
        sel_s = {dataWidth{1'b0}};
        for (int k = 0; k < numNeurons; k++) begin
            sel_s = (cnt_r == cntWidth'(k)) ? sbuf_r[k] : sel_s;
        end
    end

    // Flag and overrun next state: a transfer clears every flag, but a valid
    // landing on that same edge already belongs to the next set.
    always_comb begin
        if (transfer_s) begin
            flag_s    = layer_in_valid;
            overrun_s = overrun_r;
        end else begin
            flag_s    = flag_r | layer_in_valid;
            overrun_s = overrun_r | (|(flag_r & layer_in_valid));
        end
    end

    // Stream FSM next-state and output decode.
    always_comb begin
        state_s          = state_r;
        cnt_s            = cnt_r;
        data_out_s       = data_out_r;
        data_out_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (transfer_s) begin
                    state_s          = STREAM;
                    cnt_s            = cntWidth'(1);
                    data_out_s       = hold_r[0];
                    data_out_valid_s = 1'b1;
                end else begin
                    state_s          = IDLE;
                    cnt_s            = cntWidth'(0);
                    data_out_valid_s = 1'b0;
                end
            end
            STREAM: begin
                if (transfer_s) begin
                    // Next set starts directly behind the last element.
                    state_s          = STREAM;
                    cnt_s            = cntWidth'(1);
                    data_out_s       = hold_r[0];
                    data_out_valid_s = 1'b1;
                end else if (!last_s) begin
                    state_s          = STREAM;
                    cnt_s            = cnt_r + cntWidth'(1);
                    data_out_s       = sel_s;
                    data_out_valid_s = 1'b1;
                end else begin
                    // Set finished and nothing waiting: data_out keeps its value.
                    state_s          = IDLE;
                    cnt_s            = cntWidth'(0);
                    data_out_valid_s = 1'b0;
                end
            end
            default: begin
                state_s          = IDLE;
                cnt_s            = cntWidth'(0);
                data_out_valid_s = 1'b0;
            end
        endcase
        busy_s = (|flag_s) || (state_s == STREAM);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            cnt_r            <= cntWidth'(0);
            flag_r           <= {numNeurons{1'b0}};
            data_out_r       <= {dataWidth{1'b0}};
            data_out_valid_r <= 1'b0;
            overrun_r        <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            state_r          <= state_s;
            cnt_r            <= cnt_s;
            flag_r           <= flag_s;
            data_out_r       <= data_out_s;
            data_out_valid_r <= data_out_valid_s;
            overrun_r        <= overrun_s;
            busy_r           <= busy_s;
        end
    end

    // Holding bank capture: each neuron's latest value, last write wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < numNeurons; i++) begin
            if (rst) begin
                hold_r[i] <= {dataWidth{1'b0}};
            end else if (layer_in_valid[i]) begin
                hold_r[i] <= layer_in[i*dataWidth +: dataWidth];
            end else begin
                hold_r[i] <= hold_r[i];
            end
        end
    end

    // Shift buffer load: snapshot the completed holding bank on transfer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < numNeurons; i++) begin
            if (rst) begin
                sbuf_r[i] <= {dataWidth{1'b0}};
            end else if (transfer_s) begin
                sbuf_r[i] <= hold_r[i];
            end else begin
                sbuf_r[i] <= sbuf_r[i];
            end
        end
    end

    assign data_out       = data_out_r;
    assign data_out_valid = data_out_valid_r;
    assign busy           = busy_r;
    assign overrun        = overrun_r;

endmodule

// File: tb/tb_layer_serializer.sv
// Testbench for layer_serializer: a 4-neuron and a 1-neuron instance share
// clock and reset. A queue-based reference model predicts every output each
// cycle; directed scenarios add literal expectations on top of it.
module tb_layer_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  a_vin = 4'd0;
    logic [63:0] a_din = 64'd0;
    logic        a_dv;
    logic [15:0] a_do;
    logic        a_busy;
    logic        a_ov;

    logic [0:0]  b_vin = 1'b0;
    logic [15:0] b_din = 16'd0;
    logic        b_dv;
    logic [15:0] b_do;
    logic        b_busy;
    logic        b_ov;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    layer_serializer #(.numNeurons(4), .dataWidth(16)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .layer_in_valid (a_vin),
        .layer_in       (a_din),
        .data_out_valid (a_dv),
        .data_out       (a_do),
        .busy           (a_busy),
        .overrun        (a_ov)
    );

    layer_serializer #(.numNeurons(1), .dataWidth(16)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .layer_in_valid (b_vin),
        .layer_in       (b_din),
        .data_out_valid (b_dv),
        .data_out       (b_do),
        .busy           (b_busy),
        .overrun        (b_ov)
    );

    always #5 clk = ~clk;

    // Reference model: per-neuron pending flag/value, a FIFO of elements still
    // to be emitted, and the expected output of the current cycle.
    logic        mflag [2][4];
    logic [15:0] mhold [2][4];
    logic [15:0] mq    [2][16];
    int          mhead [2];
    int          mcnt  [2];
    logic        ev    [2];
    logic [15:0] ed    [2];
    logic        eov   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input int nn, input logic [3:0] v, input logic [63:0] dat);
        bit complete;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mflag[d][i] = 1'b0;
                mhold[d][i] = 16'd0;
            end
            mhead[d] = 0;
            mcnt[d]  = 0;
            ev[d]    = 1'b0;
            ed[d]    = 16'd0;
            eov[d]   = 1'b0;
        end else begin
            complete = 1'b1;
            for (int i = 0; i < nn; i++) if (!mflag[d][i]) complete = 1'b0;
            // A complete set moves to the emit FIFO once nothing else is pending.
            if (complete && mcnt[d] == 0) begin
                for (int i = 0; i < nn; i++) begin
                    mq[d][(mhead[d] + mcnt[d]) % 16] = mhold[d][i];
                    mcnt[d]++;
                    mflag[d][i] = 1'b0;
                end
            end
            for (int i = 0; i < nn; i++) begin
                if (v[i]) begin
                    if (mflag[d][i]) eov[d] = 1'b1;
                    mflag[d][i] = 1'b1;
                    mhold[d][i] = dat[i*16 +: 16];
                end
            end
            if (mcnt[d] > 0) begin
                ed[d]    = mq[d][mhead[d]];
                ev[d]    = 1'b1;
                mhead[d] = (mhead[d] + 1) % 16;
                mcnt[d]--;
            end else begin
                ev[d] = 1'b0;
            end
        end
    endtask

    function automatic logic exp_busy(input int d, input int nn);
        logic b;
        b = ev[d];
        for (int i = 0; i < nn; i++) b = b | mflag[d][i];
        return b;
    endfunction

    // One clock: model consumes the inputs sampled at the edge, return at negedge.
    task automatic step();
        @(posedge clk);
        model_step(0, 4, a_vin, a_din);
        model_step(1, 1, {3'd0, b_vin}, {48'd0, b_din});
        if (rst) started = 1'b1;
        @(negedge clk);
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("a_valid",   32'(a_dv),   32'(ev[0]));
            chk("a_data",    32'(a_do),   32'(ed[0]));
            chk("a_busy",    32'(a_busy), 32'(exp_busy(0, 4)));
            chk("a_overrun", 32'(a_ov),   32'(eov[0]));
            chk("b_valid",   32'(b_dv),   32'(ev[1]));
            chk("b_data",    32'(b_do),   32'(ed[1]));
            chk("b_busy",    32'(b_busy), 32'(exp_busy(1, 1)));
            chk("b_overrun", 32'(b_ov),   32'(eov[1]));
        end
    end

    logic [15:0] exp8 [8];

    initial begin
        // Reset
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_a_valid",   32'(a_dv),   32'd0);
        chk("rst_a_data",    32'(a_do),   32'd0);
        chk("rst_a_busy",    32'(a_busy), 32'd0);
        chk("rst_a_overrun", 32'(a_ov),   32'd0);
        chk("rst_b_valid",   32'(b_dv),   32'd0);
        step();

        // All four valids together
        a_vin = 4'hF;
        a_din = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        step();
        a_vin = 4'h0;
        chk("t1_no_valid_yet", 32'(a_dv),   32'd0);
        chk("t1_busy_flags",   32'(a_busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_valid", 32'(a_dv), 32'd1);
            chk("t1_data",  32'(a_do), 32'(16'h0010 * (k + 1)));
        end
        step();
        chk("t1_valid_end", 32'(a_dv),   32'd0);
        chk("t1_busy_end",  32'(a_busy), 32'd0);
        chk("t1_overrun",   32'(a_ov),   32'd0);

        // Staggered valids: neurons 3,0,2,1 at cycles 0,5,9,20
        a_din = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        for (int c = 0; c <= 20; c++) begin
            a_vin = (c == 0) ? 4'b1000 : (c == 5) ? 4'b0001 :
                    (c == 9) ? 4'b0100 : (c == 20) ? 4'b0010 : 4'b0000;
            step();
            chk("t2_no_early_valid", 32'(a_dv), 32'd0);
        end
        a_vin = 4'h0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_order", 32'(a_do), 32'(16'h1000 + k));
        end
        step();

        // Double buffering: second set collected while the first streams
        a_vin = 4'hF;
        a_din = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        step();
        a_vin = 4'h0;
        step();
        a_vin = 4'hF;
        a_din = {16'h0104, 16'h0103, 16'h0102, 16'h0101};
        exp8 = '{16'h0010, 16'h0020, 16'h0030, 16'h0040,
                 16'h0101, 16'h0102, 16'h0103, 16'h0104};
        chk("t3_first", 32'(a_do), 32'h0010);
        step();
        a_vin = 4'h0;
        for (int k = 1; k < 8; k++) begin
            chk("t3_gapless_valid", 32'(a_dv), 32'd1);
            chk("t3_gapless_data",  32'(a_do), 32'(exp8[k]));
            step();
        end
        chk("t3_done", 32'(a_dv), 32'd0);
        step();

        // Overrun: neuron 2 twice before the rest arrive
        a_vin = 4'b0100; a_din = {16'h0, 16'h00AA, 16'h0, 16'h0};
        step();
        chk("t4_no_overrun_yet", 32'(a_ov), 32'd0);
        a_vin = 4'b0100; a_din = {16'h0, 16'h00BB, 16'h0, 16'h0};
        step();
        chk("t4_overrun_set", 32'(a_ov), 32'd1);
        a_vin = 4'b1011; a_din = {16'h0003, 16'h0, 16'h0002, 16'h0001};
        step();
        a_vin = 4'h0;
        step();
        step();
        step();
        chk("t4_elem2", 32'(a_do), 32'h00BB);
        step();
        step();
        chk("t4_overrun_sticky", 32'(a_ov), 32'd1);

        // Reset on the second cycle of a stream, with a partial set pending
        a_vin = 4'hF; a_din = {16'h0558, 16'h0557, 16'h0556, 16'h0555};
        step();
        a_vin = 4'h0;
        step();
        a_vin = 4'b0010; a_din = {16'h0, 16'h0, 16'h0777, 16'h0};
        step();
        a_vin = 4'h0;
        chk("t5_streaming", 32'(a_dv), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_valid",   32'(a_dv),   32'd0);
        chk("t5_rst_busy",    32'(a_busy), 32'd0);
        chk("t5_rst_overrun", 32'(a_ov),   32'd0);
        a_vin = 4'b1101; a_din = {16'h00A3, 16'h00A2, 16'h0, 16'h00A0};
        step();
        a_vin = 4'h0;
        step();
        step();
        chk("t5_partial_discarded", 32'(a_dv), 32'd0);
        a_vin = 4'b0010; a_din = {16'h0, 16'h0, 16'h00A1, 16'h0};
        step();
        a_vin = 4'h0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_fresh", 32'(a_do), 32'(16'h00A0 + k));
        end
        step();

        // Single-neuron instance
        b_vin = 1'b1; b_din = 16'hFFFF;
        step();
        b_vin = 1'b0;
        chk("t6_pre", 32'(b_dv), 32'd0);
        step();
        chk("t6_valid", 32'(b_dv), 32'd1);
        chk("t6_data",  32'(b_do), 32'hFFFF);
        step();
        chk("t6_one_cycle", 32'(b_dv),   32'd0);
        chk("t6_idle",      32'(b_busy), 32'd0);
        chk("t6_hold_data", 32'(b_do),   32'hFFFF);

        // Randomized traffic on both instances, with rare resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                a_vin[i] = ($urandom_range(0, 5) == 0);
                a_din[i*16 +: 16] = 16'($urandom);
            end
            b_vin = ($urandom_range(0, 3) == 0);
            b_din = 16'($urandom);
            rst   = ($urandom_range(0, 399) == 0);
            step();
        end
        a_vin = 4'h0;
        b_vin = 1'b0;
        rst   = 1'b0;
        for (int k = 0; k < 12; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Sits between two neuron layers.
- Collects the parallel `neuron_out`/`neuron_out_valid` results of all neurons in one layer into a holding bank.
- Replays the collected values as a gapless serial stream, neuron 0 first, on `data_out`/`data_out_valid`.
- That stream drives `neuron_in`/`neuron_in_valid` of every neuron in the next layer.
- Holding bank plus shift buffer give double buffering: layer N+1 result collection overlaps streaming of layer N.

Parameters:
- numNeurons, 30, number of neurons in the upstream layer (>=1).
- dataWidth, 16, width of each neuron output and of data_out.
- cntWidth, $clog2(numNeurons+1), width of the stream element counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- layer_in_valid  input  numNeurons  bit i = neuron_out_valid of upstream neuron i (1-cycle pulse).
- layer_in  input  numNeurons*dataWidth  slice [i*dataWidth +: dataWidth] = neuron_out of neuron i.
- data_out_valid  output  1  high for each streamed element; drives next-layer neuron_in_valid.
- data_out  output  dataWidth  streamed element; drives next-layer neuron_in.
- busy  output  1  high while any holding flag is set or the stream is active.
- overrun  output  1  sticky error flag: a neuron delivered twice before its set was transferred.

Behaviour:
- Reset (synchronous, active-high):
  - All holding flags = 0; state = IDLE; cnt = 0.
  - data_out = 0, data_out_valid = 0, overrun = 0, busy = 0.
  - Reset mid-stream aborts the stream at the next edge; partially collected sets are discarded.
- Collect stage: per neuron i, a holding register hold[i] and a flag f[i].
  - On layer_in_valid[i]: hold[i] <= slice i; f[i] <= 1.
  - If f[i] is already 1 and is not being cleared on the same edge: value overwrites and overrun <= 1 (sticky until rst).
- Complete = AND of all f[i], using registered flags.
  - Valids arriving in the cycle being evaluated do not count until the next edge.
- State machine, states IDLE and STREAM, counter cnt:
  - Transfer condition: complete && (state == IDLE || (state == STREAM && cnt == numNeurons)).
  - On transfer:
    - sbuf[*] <= hold[*]; all f[*] <= 0.
    - A layer_in_valid[i] on the transfer edge sets f[i] <= 1 for the next set, with no overrun.
    - data_out <= hold[0]; data_out_valid <= 1; cnt <= 1; state <= STREAM.
  - STREAM with cnt < numNeurons: data_out <= sbuf[cnt]; data_out_valid <= 1; cnt <= cnt + 1.
  - STREAM with cnt == numNeurons and no transfer: data_out_valid <= 0; cnt <= 0; state <= IDLE; data_out holds its last value.
- Output guarantees:
  - Each set is exactly numNeurons consecutive valid cycles, in order neuron 0 .. numNeurons-1, with no bubbles inside a set.
  - Back-to-back sets stream with zero gap cycles.
- Latency: last layer_in_valid sampled at edge t with shifter idle -> flags complete after edge t -> transfer at edge t+1 -> first data_out_valid during cycle t+1..t+2; last element valid during cycle t+numNeurons.
- A set completing during STREAM waits in the holding bank until the current stream's last element is on the output.
- numNeurons = 1: each transfer produces one valid cycle.
- busy = (|f) || (state == STREAM).
- Arithmetic: none; values pass through bit-exact (signed fixed-point from the neuron, unchanged).

Test Plan:
- Reset then numNeurons=4: all four valids in the same cycle with values 0x0010, 0x0020, 0x0030, 0x0040 -> 4 consecutive valid cycles carrying 0x0010, 0x0020, 0x0030, 0x0040, starting 2 edges after the valids; busy drops after the last element; overrun = 0.
- Staggered valids: neurons 3, 0, 2, 1 in cycles 0, 5, 9, 20 -> no data_out_valid before the neuron-1 capture; stream order is still 0, 1, 2, 3.
- Double buffering: second full set (0x0101..0x0104) completes while the first is streaming -> 8 consecutive valid cycles, no gap, second set follows the first immediately.
- Overrun: neuron 2 valid twice (0x00AA then 0x00BB) before neurons 0, 1, 3 arrive -> overrun = 1 and stays high; streamed element 2 = 0x00BB.
- Reset asserted on the 2nd cycle of a stream -> next edge: data_out_valid = 0, busy = 0, overrun = 0; a fresh full set afterwards streams correctly from element 0.
- numNeurons=1: single valid of 0xFFFF -> exactly one data_out_valid cycle with data_out = 0xFFFF, then IDLE.
